// File: rtl/uart_rx_fifo_if.sv
// Sensor-side drain handshake for uart_rx_fifo: head word, valid, ready.
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] sensor_data;
  logic                  sensor_valid;
  logic                  sensor_ready;

  modport master (output sensor_data, output sensor_valid, input sensor_ready);
  modport slave  (input sensor_data, input sensor_valid, output sensor_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with optional parity, 1/2 stop bits, false-start rejection,
// sticky error flags and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int BAUD_RATE   = 115200,
  parameter int CLK_FREQ    = 100_000_000,
  parameter int FIFO_DEPTH  = 4,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_sig,
  uart_rx_fifo_if.master              sensor,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overrun,
  input  logic                        err_clr
);
  localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W       = $clog2(PULSE_WIDTH) + 1;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int BIT_W       = $clog2(DATA_WIDTH) + 1;

  localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(PULSE_WIDTH / 2);
  localparam logic [CNT_W-1:0] FULL_BIT  = CNT_W'(PULSE_WIDTH);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam logic [PTR_W:0]   DEPTH     = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic             ODD       = (PARITY_ODD != 0);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic                  rx_s1, rx_s2, rx_prev;
  logic [2:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [BIT_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bad, frm_bad;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;

  logic fall, tick, commit, frame_bad_now, good, pop, full, push;
  logic set_frm, set_par, set_ovr;

  assign fall          = rx_prev & ~rx_s2;
  assign tick          = (cnt == CNT_W'(1));
  assign commit        = (state == ST_STOP) && tick && (bit_idx == LAST_STOP);
  assign frame_bad_now = frm_bad | ~rx_s2;
  assign good          = commit & ~frame_bad_now & ~par_bad;
  assign pop           = sensor.sensor_valid & sensor.sensor_ready;
  assign full          = (fifo_count == DEPTH);
  assign push          = good & (~full | pop);
  assign set_ovr       = good & full & ~pop;
  assign set_frm       = commit & frame_bad_now;
  assign set_par       = commit & ~frame_bad_now & par_bad;

  // Synchroniser stage; flops idle high so reset never looks like a start edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_sig;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Frame FSM stage: mid-bit sampling off a down-counter that expires at 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      par_bad <= 1'b0;
      frm_bad <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (fall) begin
        cnt     <= HALF_BIT;
        bit_idx <= '0;
        par_bad <= 1'b0;
        frm_bad <= 1'b0;
        state   <= ST_START;
      end
    end else begin
      cnt <= tick ? FULL_BIT : cnt - CNT_W'(1);
      if (tick) begin
        case (state)
          ST_START: state <= rx_s2 ? ST_IDLE : ST_DATA;
          ST_DATA: begin
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              state   <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
            end
          end
          ST_PARITY: begin
            par_bad <= ((^shreg) ^ rx_s2) != ODD;
            state   <= ST_STOP;
          end
          ST_STOP: begin
            if (!rx_s2) frm_bad <= 1'b1;
            if (bit_idx == LAST_STOP) state <= ST_IDLE;
            else bit_idx <= bit_idx + BIT_W'(1);
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state == ST_DATA) && tick) shreg <= {rx_s2, shreg[DATA_WIDTH-1:1]};
  end

  // FIFO stage: storage unreset, output gated so an empty FIFO reads zero
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign sensor.sensor_valid = (fifo_count != '0);
  assign sensor.sensor_data  = sensor.sensor_valid ? mem[rd_ptr] : '0;

  // Sticky flag stage: a fresh error wins over a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= (frame_err  & ~err_clr) | set_frm;
      parity_err <= (parity_err & ~err_clr) | set_par;
      overrun    <= (overrun    & ~err_clr) | set_ovr;
    end
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver with a first-word-fall-through receive FIFO, replacing the single-byte overwrite buffer between the PC link and the sensor interface. It adds optional parity, 1 or 2 stop bits, false-start rejection, error detection and a FIFO of configurable depth. Received words drain to the sensor side through a valid/ready handshake.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9), LSB first
BAUD_RATE, 115200, line bit rate
CLK_FREQ, 100_000_000, clk frequency in Hz; PULSE_WIDTH = CLK_FREQ/BAUD_RATE clocks per bit (integer divide)
FIFO_DEPTH, 4, number of FIFO entries; power of two, at least 2
PARITY_EN, 0, 1 = a parity bit follows the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
rx_sig  in  1  asynchronous serial line, idle high
sensor_ready  in  1  consumer accepts the head word
sensor_data  out  DATA_WIDTH  FIFO head word
sensor_valid  out  1  FIFO not empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
frame_err  out  1  sticky: a stop bit was sampled low
parity_err  out  1  sticky: parity mismatch
overrun  out  1  sticky: a good word arrived while the FIFO was full
err_clr  in  1  single-cycle pulse that clears all three sticky flags

Behaviour:
- Reset (async, active-high): FSM to IDLE; synchroniser flops set to 1; FIFO pointers and fifo_count 0; sensor_valid 0; sensor_data 0; all error flags 0. Asserting rst mid-frame abandons the frame, and nothing is written.
- rx_sig passes through a 2-FF synchroniser. Edge detection uses the synchronised value and its previous value.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on a synchronised falling edge, load the bit counter with PULSE_WIDTH/2 and go to START.
- START: at counter expiry (mid-bit), sample. If the sample is 1, treat it as a false start and return to IDLE with no flag. If 0, reload PULSE_WIDTH and go to DATA.
- DATA: take DATA_WIDTH samples at mid-bit, LSB first, into a shift register. Then go to PARITY if PARITY_EN, else to STOP.
- PARITY: sample once. Mismatch marks the frame bad-parity.
- STOP: take STOP_BITS samples. Any low sample marks the frame bad-framing.
- At the last stop sample, the FSM returns to IDLE. A new falling edge is then required, so a held-low line (break) raises one frame_err only.
- Commit at the last stop sample:
  - framing error: set frame_err, discard the word (parity not checked);
  - parity error only: set parity_err, discard the word;
  - good word and (count < FIFO_DEPTH, or a pop in the same cycle): push;
  - good word and FIFO full with no pop: set overrun, drop the new word; FIFO contents are untouched (the oldest data is preserved).
- FIFO is first-word-fall-through. sensor_data equals the head entry combinationally from registered storage. sensor_valid = (count != 0).
- Pop occurs on a cycle where sensor_valid && sensor_ready.
- Push and pop in the same cycle leave count unchanged. Push and pop are both legal when full, and push-only is legal when empty.
- Latency: a word pushed in cycle N is visible on sensor_valid/sensor_data in cycle N+1.
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. fifo_count saturates structurally at FIFO_DEPTH, never exceeding it.
- sensor_ready while empty has no effect.
- Sticky flags stay set until err_clr. If err_clr and a new error of the same kind occur in the same cycle, the flag ends that cycle set.
- The bit counter width is $clog2(PULSE_WIDTH)+1 and it counts down to 1.

Test Plan:
- Defaults (PULSE_WIDTH=868): send 0xA5 with sensor_ready=0, then 0x5A; then raise sensor_ready -> sensor_valid high with count 1 then 2; 0xA5 accepted, then 0x5A, then sensor_valid drops; no error flags.
- FIFO_DEPTH=4, sensor_ready=0: send 0x11, 0x22, 0x33, 0x44, 0x55 -> count 4, overrun=1; drain yields 0x11..0x44 in order, and 0x55 is absent; err_clr -> overrun=0.
- sensor_ready=1 before the frame: send 0xC3 -> sensor_valid high for exactly 1 cycle, sensor_data=0xC3, count returns to 0.
- Glitch: pulse rx_sig low for 200 clocks -> false start; no push, no flags, FSM back in IDLE; a following 0x3C is received correctly.
- Stop bit driven 0 on 0x7E -> frame_err=1, count unchanged. With PARITY_EN=1, PARITY_ODD=0: send 0x01 with parity bit 0 -> parity_err=1, word discarded; with parity bit 1 -> word accepted.
- Assert rst mid-DATA of 0xF0 -> all outputs 0 and FIFO empty. A full frame 0x0F sent after reset release is received as 0x0F.
